// File: rtl/hazard_ctrl_pkg.sv
// rtl/hazard_ctrl_pkg.sv - result-class, forward-select and Tnew definitions shared with the tracker
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        RES_NW  = 2'b00,
        RES_ALU = 2'b01,
        RES_DM  = 2'b10,
        RES_PC  = 2'b11
    } res_t;

    localparam logic [1:0] FWD_RF   = 2'b00;
    localparam logic [1:0] FWD_E_PC = 2'b01;
    localparam logic [1:0] FWD_M    = 2'b10;
    localparam logic [1:0] FWD_W    = 2'b11;

    localparam logic [1:0] TUSE_D = 2'd0;
    localparam logic [1:0] TUSE_E = 2'd1;
    localparam logic [1:0] TUSE_M = 2'd2;

    // Cycles until a producer in E has its value ready, by result class.
    function automatic logic [1:0] tnew_e(input logic [1:0] res);
        case (res)
            RES_ALU: tnew_e = 2'd1;
            RES_DM:  tnew_e = 2'd2;
            default: tnew_e = 2'd0;
        endcase
    endfunction

    function automatic logic [1:0] tnew_m(input logic [1:0] res);
        tnew_m = (res == RES_DM) ? 2'd1 : 2'd0;
    endfunction

endpackage

// File: rtl/hazard_ctrl_md_busy_seq.sv
// rtl/hazard_ctrl_md_busy_seq.sv - mult/div busy countdown (IDLE/BUSY)
module md_busy_seq
    import hazard_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic is_div,
    output logic busy
);

    localparam int MAX_CYCLES = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
    localparam int CW = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
        end else if (start) begin
            // A start while already busy restarts the countdown.
            state <= BUSY;
            cnt   <= is_div ? CW'(DIV_CYCLES - 1) : CW'(MULT_CYCLES - 1);
            busy  <= 1'b1;
        end else if (state == BUSY) begin
            if (cnt == '0) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - D-stage stall detection, forwarding selects and stall counter
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tuse_rs0,
    input  logic             tuse_rs1,
    input  logic             tuse_rt0,
    input  logic             tuse_rt1,
    input  logic             tuse_rt2,
    input  logic [4:0]       a1_d,
    input  logic [4:0]       a2_d,
    input  logic [4:0]       a1_e,
    input  logic [4:0]       a2_e,
    input  logic [4:0]       a3_e,
    input  logic [4:0]       a2_m,
    input  logic [4:0]       a3_m,
    input  logic [4:0]       a3_w,
    input  logic [1:0]       res_e,
    input  logic [1:0]       res_m,
    input  logic [1:0]       res_w,
    input  logic             md_d,
    input  logic             md_start_e,
    input  logic             md_div_e,
    output logic             stall,
    output logic [1:0]       fwd_rs_d,
    output logic [1:0]       fwd_rt_d,
    output logic [1:0]       fwd_rs_e,
    output logic [1:0]       fwd_rt_e,
    output logic             fwd_rt_m,
    output logic             md_busy,
    output logic [CNT_W-1:0] stall_cnt
);

    logic data_stall;
    logic md_stall;

    // True when a producer in E or M will not have reg ready by time tuse.
    function automatic logic late(input logic [4:0] r, input logic [1:0] tuse,
                                  input logic [4:0] ae, input logic [1:0] re,
                                  input logic [4:0] am, input logic [1:0] rm);
        late = (r != 5'd0) &&
               (((ae == r) && (re != RES_NW) && (tnew_e(re) > tuse)) ||
                ((am == r) && (rm != RES_NW) && (tnew_m(rm) > tuse)));
    endfunction

    function automatic logic [1:0] sel_d(input logic [4:0] r,
                                         input logic [4:0] ae, input logic [1:0] re,
                                         input logic [4:0] am, input logic [1:0] rm,
                                         input logic [4:0] aw, input logic [1:0] rw);
        if (r == 5'd0)                                          sel_d = FWD_RF;
        else if (ae == r && re == RES_PC)                       sel_d = FWD_E_PC;
        else if (am == r && (rm == RES_ALU || rm == RES_PC))    sel_d = FWD_M;
        else if (aw == r && rw != RES_NW)                       sel_d = FWD_W;
        else                                                    sel_d = FWD_RF;
    endfunction

    function automatic logic [1:0] sel_e(input logic [4:0] r,
                                         input logic [4:0] am, input logic [1:0] rm,
                                         input logic [4:0] aw, input logic [1:0] rw);
        if (r == 5'd0)                                          sel_e = FWD_RF;
        else if (am == r && (rm == RES_ALU || rm == RES_PC))    sel_e = FWD_M;
        else if (aw == r && rw != RES_NW)                       sel_e = FWD_W;
        else                                                    sel_e = FWD_RF;
    endfunction

    always_comb begin
        data_stall = (tuse_rs0 && late(a1_d, TUSE_D, a3_e, res_e, a3_m, res_m)) ||
                     (tuse_rs1 && late(a1_d, TUSE_E, a3_e, res_e, a3_m, res_m)) ||
                     (tuse_rt0 && late(a2_d, TUSE_D, a3_e, res_e, a3_m, res_m)) ||
                     (tuse_rt1 && late(a2_d, TUSE_E, a3_e, res_e, a3_m, res_m)) ||
                     (tuse_rt2 && late(a2_d, TUSE_M, a3_e, res_e, a3_m, res_m));
        md_stall   = md_d && (md_busy || md_start_e);
        stall      = data_stall || md_stall;

        fwd_rs_d = sel_d(a1_d, a3_e, res_e, a3_m, res_m, a3_w, res_w);
        fwd_rt_d = sel_d(a2_d, a3_e, res_e, a3_m, res_m, a3_w, res_w);
        fwd_rs_e = sel_e(a1_e, a3_m, res_m, a3_w, res_w);
        fwd_rt_e = sel_e(a2_e, a3_m, res_m, a3_w, res_w);
        fwd_rt_m = (a2_m != 5'd0) && (a2_m == a3_w) && (res_w != RES_NW);
    end

    md_busy_seq #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) u_md_busy_seq (
        .clk    (clk),
        .reset  (reset),
        .start  (md_start_e),
        .is_div (md_div_e),
        .busy   (md_busy)
    );

    always_ff @(posedge clk) begin
        if (reset)
            stall_cnt <= '0;
        else if (stall && (stall_cnt != '1))
            stall_cnt <= stall_cnt + 1'b1;
    end

endmodule
